// File: rtl/rdiv32_if.sv
// Start/done handshake and operand/result bus for the rdiv32 iterative divider.
interface rdiv32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_dividend;
  logic [WIDTH-1:0] op_divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op_dividend, op_divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, op_dividend, op_divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/rdiv32.sv
// Iterative restoring divider: one quotient bit per clock behind a start/done handshake.
// Define RDIV_SIGNED_EN for two's-complement operands (latency unchanged).
module rdiv32 #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  rdiv32_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sr;
  logic [WIDTH-1:0] quo_sr;
  logic [WIDTH-1:0] div_sr;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic             accept;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;
  logic             rem_msb_unused;

  assign accept = (state != EXEC) && bus.start;

  // One restoring step: a set sign bit in the trial difference means restore.
  always_comb begin
    r_shift = {rem_sr[WIDTH-1:0], quo_sr[WIDTH-1]};
    r_trial = r_shift - {1'b0, div_sr};
    r_next  = r_trial[WIDTH] ? r_shift : r_trial;
    q_next  = {quo_sr[WIDTH-2:0], ~r_trial[WIDTH]};
  end

  // Partial remainder never exceeds the divisor, so its top bit carries no information.
  assign rem_msb_unused = rem_sr[WIDTH];

`ifdef RDIV_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  always_comb begin
    a_mag   = bus.op_dividend[WIDTH-1] ? WIDTH'(-bus.op_dividend) : bus.op_dividend;
    b_mag   = bus.op_divisor[WIDTH-1]  ? WIDTH'(-bus.op_divisor)  : bus.op_divisor;
    quo_fin = neg_quo ? WIDTH'(-q_next) : q_next;
    rem_fin = neg_rem ? WIDTH'(-r_next[WIDTH-1:0]) : r_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_quo <= bus.op_dividend[WIDTH-1] ^ bus.op_divisor[WIDTH-1];
      neg_rem <= bus.op_dividend[WIDTH-1];
    end
  end
`else
  always_comb begin
    a_mag   = bus.op_dividend;
    b_mag   = bus.op_divisor;
    quo_fin = q_next;
    rem_fin = r_next[WIDTH-1:0];
  end
`endif

  // Control and datapath; results only update on the final step or a divide-by-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_sr      <= '0;
      quo_sr      <= '0;
      div_sr      <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
          if (accept) begin
            if (bus.op_divisor == '0) begin
              state       <= DONE;
              quotient_r  <= '1;
              remainder_r <= bus.op_dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
            end else begin
              state  <= EXEC;
              busy_r <= 1'b1;
              rem_sr <= '0;
              quo_sr <= a_mag;
              div_sr <= b_mag;
              cnt    <= '0;
              dbz_r  <= 1'b0;
            end
          end
        end
        EXEC: begin
          rem_sr <= r_next;
          quo_sr <= q_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            cnt         <= '0;
            quotient_r  <= quo_fin;
            remainder_r <= rem_fin;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_rdiv32.sv
// Self-checking bench for rdiv32: per-cycle comparison against a behavioural divide model plus directed literals.
module tb_rdiv32;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   run_chk = 1'b0;

  rdiv32_if #(.WIDTH(W)) bus ();

  rdiv32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef RDIV_SIGNED_EN
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    if (a == most_neg && b == '1) begin
      q = a;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
`else
    q = a / b;
    r = a % b;
`endif
  endfunction

  // Behavioural model: countdown to done, results computed at acceptance.
  logic         m_busy, m_done, m_z;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_z = 1'b0;
      m_q = '0; m_r = '0; p_q = '0; p_r = '0; left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        left--;
        if (left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
        end
      end else if (bus.start) begin
        if (bus.op_divisor == '0) begin
          m_done = 1'b1; m_q = '1; m_r = bus.op_dividend; m_z = 1'b1;
        end else begin
          m_busy = 1'b1; left = W; m_z = 1'b0;
          ref_div(bus.op_dividend, bus.op_divisor, p_q, p_r);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("quotient", 64'(bus.quotient), 64'(m_q));
      chk("remainder", 64'(bus.remainder), 64'(m_r));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_z));
    end
  end

  // Drive a one-cycle start from a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op_dividend = a; bus.op_divisor = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op_dividend = $urandom; bus.op_divisor = $urandom;
  endtask

  task automatic wait_done(output int n, output bit saw_busy);
    n = 0;
    saw_busy = bus.busy;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
      saw_busy |= bus.busy;
    end
  endtask

  task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez, input int elat);
    int n;
    bit sb;
    start_op(a, b);
    wait_done(n, sb);
    chk({name, " latency"}, 64'(n), 64'(elat));
    chk({name, " quotient"}, 64'(bus.quotient), 64'(eq));
    chk({name, " remainder"}, 64'(bus.remainder), 64'(er));
    chk({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(ez));
    chk({name, " busy seen"}, 64'(sb), 64'(!ez));
  endtask

  initial begin
    int n;
    bit sb;
    reset = 1'b1;
    bus.start = 1'b0; bus.op_dividend = '0; bus.op_divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset quotient", 64'(bus.quotient), 64'd0);
    chk("reset remainder", 64'(bus.remainder), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b0;
    run_chk = 1'b1;
    @(negedge clk);

    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W);
    @(negedge clk);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W);
    @(negedge clk);
    run_div("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, W);
    @(negedge clk);
    run_div("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0);
    @(negedge clk);

    // Start while busy is ignored; start during done is accepted.
    start_op(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    start_op(32'd50, 32'd5);
    wait_done(n, sb);
    chk("busy-ignore latency", 64'(n), 64'(W - 10));
    chk("busy-ignore quotient", 64'(bus.quotient), 64'd100);
    chk("busy-ignore remainder", 64'(bus.remainder), 64'd0);
    start_op(32'd9, 32'd4);
    chk("b2b busy", 64'(bus.busy), 64'd1);
    chk("b2b done", 64'(bus.done), 64'd0);
    wait_done(n, sb);
    chk("b2b latency", 64'(n), 64'(W));
    chk("b2b quotient", 64'(bus.quotient), 64'd2);
    chk("b2b remainder", 64'(bus.remainder), 64'd1);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    start_op(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async quotient", 64'(bus.quotient), 64'd0);
    chk("async remainder", 64'(bus.remainder), 64'd0);
    chk("async busy", 64'(bus.busy), 64'd0);
    chk("async done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_div("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, W);
    @(negedge clk);

`ifdef RDIV_SIGNED_EN
    run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W);
    @(negedge clk);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, W);
    @(negedge clk);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, W);
    @(negedge clk);
`endif

    // Random traffic, including starts while busy and during done.
    for (int i = 0; i < 6000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op_dividend = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 7))
        0:       bus.op_divisor = '0;
        1, 2:    bus.op_divisor = W'($urandom_range(1, 15));
        3:       bus.op_divisor = '1;
        default: bus.op_divisor = $urandom >> $urandom_range(0, 31);
      endcase
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
